// File: rtl/vetor_pkg.sv
// rtl/vetor_pkg.sv - shared state, mode encodings and default sizes for vetor_seq
package vetor_pkg;

   localparam int VETOR_WIDTH_DEF = 32;
   localparam int VETOR_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CARGA = 2'd1,
      ST_ENVIO = 2'd2
   } estado_t;

   localparam logic [1:0] MODO_PASSA = 2'b00;
   localparam logic [1:0] MODO_BYTE  = 2'b01;
   localparam logic [1:0] MODO_BIT   = 2'b10;
   localparam logic [1:0] MODO_META  = 2'b11;

endpackage

// File: rtl/vetor_manip_core.sv
// rtl/vetor_manip_core.sv - combinational word transform: passthrough, byte reverse, bit reverse, half swap
module vetor_manip_core
   import vetor_pkg::*;
#(
   parameter int WIDTH = VETOR_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] word_i,
   input  logic [1:0]       modo_i,
   output logic [WIDTH-1:0] word_o
);

   localparam int NB = WIDTH / 8;
   localparam int HW = WIDTH / 2;

   logic [WIDTH-1:0] byte_rev;
   logic [WIDTH-1:0] bit_rev;

   always_comb begin
      byte_rev = '0;
      bit_rev  = '0;
      for (int b = 0; b < NB; b++) begin
         byte_rev[8*b +: 8] = word_i[8*(NB-1-b) +: 8];
      end
      for (int i = 0; i < WIDTH; i++) begin
         bit_rev[i] = word_i[WIDTH-1-i];
      end
      case (modo_i)
         MODO_BYTE: word_o = byte_rev;
         MODO_BIT:  word_o = bit_rev;
         MODO_META: word_o = {word_i[HW-1:0], word_i[WIDTH-1:HW]};
         default:   word_o = word_i;
      endcase
   end

endmodule

// File: rtl/vetor_seq.sv
// rtl/vetor_seq.sv - batch load/emit sequencer with per-batch word transform; VETOR_SEQ_CONTADOR_EN adds batch_count
module vetor_seq
   import vetor_pkg::*;
#(
   parameter int WIDTH = VETOR_WIDTH_DEF,
   parameter int DEPTH = VETOR_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic [1:0]       modo,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy
`ifdef VETOR_SEQ_CONTADOR_EN
   ,
   output logic [15:0]      batch_count
`endif
);

   localparam int PW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   estado_t          state_q, state_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    len_q, len_d;
   logic [1:0]       modo_q, modo_d;
   logic [WIDTH-1:0] buf_q [DEPTH];

   logic             accept;
   logic             emit;
   logic             is_last_rd;
   logic [PW-1:0]    wr_cnt_next;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] manip_word;

   // Outputs are gated by rst so nothing leaks out of a batch being discarded.
   assign in_ready    = !rst && (state_q != ST_ENVIO);
   assign out_valid   = !rst && (state_q == ST_ENVIO);
   assign busy        = !rst && (state_q != ST_IDLE);
   assign accept      = in_valid && in_ready;
   assign emit        = out_valid && out_ready;
   assign is_last_rd  = (rd_ptr_q == len_q - PW'(1));
   assign out_last    = out_valid && is_last_rd;
   assign out_data    = out_valid ? manip_word : '0;
   assign wr_cnt_next = wr_ptr_q + PW'(1);
   assign wr_addr     = (state_q == ST_IDLE) ? '0 : wr_ptr_q[AW-1:0];

   vetor_manip_core #(
      .WIDTH (WIDTH)
   ) u_manip (
      .word_i (buf_q[rd_ptr_q[AW-1:0]]),
      .modo_i (modo_q),
      .word_o (manip_word)
   );

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      len_d    = len_q;
      modo_d   = modo_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               modo_d   = modo;
               wr_ptr_d = PW'(1);
               if (in_last) begin
                  state_d  = ST_ENVIO;
                  len_d    = PW'(1);
                  rd_ptr_d = '0;
               end else begin
                  state_d = ST_CARGA;
               end
            end
         end
         ST_CARGA: begin
            if (accept) begin
               wr_ptr_d = wr_cnt_next;
               // A full buffer closes the batch even without in_last.
               if (in_last || (wr_cnt_next == PW'(DEPTH))) begin
                  state_d  = ST_ENVIO;
                  len_d    = wr_cnt_next;
                  rd_ptr_d = '0;
               end
            end
         end
         ST_ENVIO: begin
            if (emit) begin
               if (is_last_rd) begin
                  state_d  = ST_IDLE;
                  rd_ptr_d = '0;
                  wr_ptr_d = '0;
               end else begin
                  rd_ptr_d = rd_ptr_q + PW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         len_q    <= '0;
         modo_q   <= MODO_PASSA;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         len_q    <= len_d;
         modo_q   <= modo_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         buf_q[wr_addr] <= in_data;
      end
   end

`ifdef VETOR_SEQ_CONTADOR_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (emit && is_last_rd) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign batch_count = cnt_q;
`endif

endmodule
